// File: rtl/cs_ip_scheduler.sv
// Round-robin scheduler sharing one checksum core among NUM_REQ requesters, one job in flight.
// Optional WAIT timeout is built when CS_IP_SCHEDULER_TIMEOUT_EN is defined.
module cs_ip_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH_DATA   = 256,
  parameter int WIDTH_RESULT = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WIDTH_DATA-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH_RESULT-1:0]       rsp_result,
  output logic                          rsp_err,
  output logic [WIDTH_DATA-1:0]         ip_data,
  output logic                          ip_in_valid,
  input  logic [WIDTH_RESULT-1:0]       ip_result,
  input  logic                          ip_out_valid,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  int               cand;

`ifdef CS_IP_SCHEDULER_TIMEOUT_EN
  logic [9:0] wait_cnt;
  logic       err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Search starts just past the last-served requester, so it has lowest priority.
  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  assign req_ready = (state == S_IDLE && !rst && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;

  // NOTE: state and registered outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      rsp_valid   <= '0;
      rsp_result  <= '0;
      ip_in_valid <= 1'b0;
      ip_data     <= '0;
      busy        <= 1'b0;
`ifdef CS_IP_SCHEDULER_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      ip_in_valid <= 1'b0;
      rsp_valid   <= '0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            ip_data     <= req_data[int'(grant_idx)*WIDTH_DATA +: WIDTH_DATA];
            owner       <= grant_idx;
            ptr         <= grant_idx;
            ip_in_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef CS_IP_SCHEDULER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (ip_out_valid) begin
            rsp_result <= ip_result;
            rsp_valid  <= NUM_REQ'(1) << owner;
            state      <= S_RESP;
`ifdef CS_IP_SCHEDULER_TIMEOUT_EN
            err_q      <= 1'b0;
          end else if (wait_cnt == 10'(TIMEOUT - 1)) begin
            rsp_result <= '0;
            rsp_valid  <= NUM_REQ'(1) << owner;
            err_q      <= 1'b1;
            state      <= S_RESP;
          end else begin
            wait_cnt   <= wait_cnt + 10'd1;
`endif
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_ip_scheduler.sv
// Directed self-checking bench for cs_ip_scheduler; the core is emulated by driving ip_out_valid by hand.
module tb_cs_ip_scheduler;

  localparam int NUM = 4;
  localparam int W   = 256;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM-1:0]     req_valid;
  logic [NUM*W-1:0]   req_data;
  logic [NUM-1:0]     req_ready;
  logic [NUM-1:0]     rsp_valid;
  logic [0:0]         rsp_result;
  logic               rsp_err;
  logic [W-1:0]       ip_data;
  logic               ip_in_valid;
  logic [0:0]         ip_result;
  logic               ip_out_valid;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  cs_ip_scheduler #(
    .NUM_REQ(NUM), .WIDTH_DATA(W), .WIDTH_RESULT(1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .ip_data(ip_data), .ip_in_valid(ip_in_valid),
    .ip_result(ip_result), .ip_out_valid(ip_out_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
  endtask

  // Runs one job from acceptance (caller is in IDLE with inputs set) to the IDLE cycle after RESP.
  task automatic do_job(input int g, input int lat, input bit hold, input bit spur, input string tag);
    logic [W-1:0] d;
    logic         res;
    d   = req_data[g*W +: W];
    res = ^d;
    #1;
    check($sformatf("%s_ready", tag), req_ready, NUM'(1) << g);
    check($sformatf("%s_idle_busy", tag), busy, 0);
    step();
    if (!hold) req_valid[g] = 1'b0;
    check($sformatf("%s_issue", tag), ip_in_valid, 1);
    check($sformatf("%s_data", tag), ip_data, d);
    check($sformatf("%s_busy", tag), busy, 1);
    if (spur) begin
      ip_out_valid = 1'b1;
      ip_result    = ~res;
    end
    for (int c = 1; c <= lat; c++) begin
      step();
      ip_out_valid = 1'b0;
      check($sformatf("%s_issue_once_%0d", tag, c), ip_in_valid, 0);
      check($sformatf("%s_no_rsp_%0d", tag, c), rsp_valid, 0);
      if (c == lat) begin
        ip_out_valid = 1'b1;
        ip_result    = res;
      end
    end
    step();
    ip_out_valid = 1'b0;
    check($sformatf("%s_rsp_valid", tag), rsp_valid, NUM'(1) << g);
    check($sformatf("%s_rsp_result", tag), rsp_result, res);
    check($sformatf("%s_rsp_err", tag), rsp_err, 0);
    check($sformatf("%s_resp_ready", tag), req_ready, 0);
    step();
    check($sformatf("%s_rsp_pulse", tag), rsp_valid, 0);
    check($sformatf("%s_back_idle", tag), busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_order[8];
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst          = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    ip_result    = '0;
    ip_out_valid = 1'b0;

    // Reset values, and no acceptance while rst is high.
    step();
    step();
    req_valid = 4'b0001;
    set_slot(0, 256'h1);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_in_valid", ip_in_valid, 0);
    check("rst_ip_data", ip_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Single job, L=3: response 5 cycles after acceptance.
    do_job(0, 3, 0, 0, "t1");

    // All requesters active: strict rotation starting at 0 after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_slot(1, 256'h3);
    set_slot(2, 256'h7);
    set_slot(3, 256'hDEAD_BEEF);
    req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) do_job(exp_order[j], 1 + (j % 3), 1, 0, $sformatf("t2_j%0d", j));
    req_valid = '0;

    // Requester 2 arrives while requester 1 is in WAIT.
    req_valid = 4'b0010;
    #1;
    check("t3_ready_r1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0000;
    check("t3_issue", ip_in_valid, 1);
    step();
    req_valid = 4'b0100;
    #1;
    check("t3_ready_wait1", req_ready, 0);
    step();
    check("t3_ready_wait2", req_ready, 0);
    ip_out_valid = 1'b1;
    ip_result    = 1'b0;
    step();
    ip_out_valid = 1'b0;
    check("t3_rsp_r1", rsp_valid, 4'b0010);
    check("t3_ready_resp", req_ready, 0);
    step();
    do_job(2, 2, 0, 0, "t3_r2");

    // Spurious core pulses in IDLE and ISSUE.
    ip_out_valid = 1'b1;
    ip_result    = 1'b1;
    step();
    ip_out_valid = 1'b0;
    check("t4_idle_no_rsp", rsp_valid, 0);
    check("t4_idle_busy", busy, 0);
    req_valid = 4'b1000;
    do_job(3, 3, 0, 1, "t4");

    // Reset during WAIT aborts the job; requester 0 wins first afterwards.
    req_valid = 4'b0010;
    #1;
    check("t5_ready_r1", req_ready, 4'b0010);
    step();
    req_valid = 4'b0000;
    step();
    step();
    rst       = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("t5_ready_in_rst", req_ready, 0);
    step();
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rsp_valid", rsp_valid, 0);
    check("t5_rst_in_valid", ip_in_valid, 0);
    check("t5_rst_ip_data", ip_data, 0);
    rst = 1'b0;
    do_job(0, 2, 0, 0, "t5");
    req_valid = '0;

`ifdef CS_IP_SCHEDULER_TIMEOUT_EN
    // TIMEOUT=4, core silent: error response 6 cycles after acceptance.
    set_slot(1, 256'h1);
    ip_result = 1'b1;
    req_valid = 4'b0010;
    #1;
    check("t6_ready", req_ready, 4'b0010);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) req_valid = 4'b0000;
      check($sformatf("t6_no_rsp_%0d", c), rsp_valid, 0);
    end
    step();
    check("t6_to_valid", rsp_valid, 4'b0010);
    check("t6_to_err", rsp_err, 1);
    check("t6_to_result", rsp_result, 0);
    step();
    check("t6_to_pulse", rsp_valid, 0);
    ip_out_valid = 1'b1;
    step();
    ip_out_valid = 1'b0;
    check("t6_late_ignored", rsp_valid, 0);
    check("t6_late_busy", busy, 0);
    // Core answers in the timeout cycle itself: the answer wins.
    req_valid = 4'b0010;
    do_job(1, 4, 0, 0, "t6_coinc");
`else
    // Without the timeout a slow core is simply waited for.
    set_slot(1, 256'h1);
    req_valid = 4'b0010;
    do_job(1, 12, 0, 0, "t6_long");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cs_ip_scheduler.md
# cs_ip_scheduler

Round-robin scheduler that shares one checksum IP instance (256-bit `data`/`in_valid` in, 1-bit `result`/`out_valid` out) between `NUM_REQ` requesters. It sits between the requester ports and the checksum core. It accepts one request at a time, issues it to the core as a single-cycle `in_valid` pulse and waits for `out_valid`. It then returns the result to the requester that owns the job. Only one job is in flight at any time.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `WIDTH_DATA`, 256: data width per request; must match the checksum core.
- `WIDTH_RESULT`, 1: result width; must match the checksum core.
- `TIMEOUT`, 255: maximum number of WAIT cycles before the job is aborted. Used only when the timeout macro is enabled; legal range 1..1023.
- `clk` input 1: single clock; every register updates on its rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `req_valid` input NUM_REQ: bit i is set when requester i has a job pending.
- `req_data` input NUM_REQ*WIDTH_DATA: requester i owns slice [i*WIDTH_DATA +: WIDTH_DATA].
- `req_ready` output NUM_REQ: one-hot acceptance strobe, combinational.
- `rsp_valid` output NUM_REQ: one-hot, registered; a single-cycle pulse to the job owner.
- `rsp_result` output WIDTH_RESULT: checksum result; qualified by any `rsp_valid` bit.
- `rsp_err` output 1: the job timed out; qualified by `rsp_valid`.
- `ip_data` output WIDTH_DATA: data to the core `data` port.
- `ip_in_valid` output 1: to the core `in_valid` port.
- `ip_result` input WIDTH_RESULT: from the core `result` port.
- `ip_out_valid` input 1: from the core `out_valid` port.
- `busy` output 1: high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP; IDLE is the reset state.
- **IDLE**
  - The grant `g` is the first index i with `req_valid[i]=1`, searching from `ptr+1` upward with modulo NUM_REQ wrap.
  - `req_ready[g]=1` in the same cycle; that acceptance is the handshake.
  - At that edge: `req_data[g]` is latched into the data register, `owner<=g`, `ptr<=g`, and the FSM moves to ISSUE.
  - If no `req_valid` bit is set, `req_ready=0` and the FSM stays in IDLE.
- **ISSUE**
  - `ip_in_valid=1` for exactly one cycle, with `ip_data` driven from the data register. Next state is WAIT.
  - `ip_out_valid` is ignored in this state.
- **WAIT**
  - When `ip_out_valid=1`: `ip_result` is latched, the error flag is cleared and the FSM moves to RESP.
- **RESP**
  - `rsp_valid[owner]=1`, with the latched result on `rsp_result` and the error flag on `rsp_err`. Next state is IDLE.
- `ip_out_valid` is ignored in IDLE, ISSUE and RESP.
- `ip_data` holds its last value when `ip_in_valid=0`.
- `req_ready` is 0 in every state except IDLE, so requests presented while the block is busy wait.
- Requesters must hold `req_valid` and `req_data` stable until `req_ready` is seen. Dropping `req_valid` before acceptance is legal; that requester is simply skipped.
- Fairness: the requester just served has the lowest priority on the next arbitration. With all requesters always active, the grant order is 0,1,2,…,NUM_REQ-1,0,…

## Timing
- Reset (`rst=1` at an edge):
  - state becomes IDLE and `ptr` becomes NUM_REQ-1, so requester 0 wins first.
  - `rsp_valid`, `rsp_result`, `rsp_err`, `ip_in_valid`, `ip_data` and `busy` are all 0.
  - `req_ready` is 0 while `rst` is high.
- Reset mid-job aborts the job; no response is ever produced for it. The core shares `rst`, so it is reset along with the scheduler.
- Latency:
  - Acceptance at cycle T gives `ip_in_valid` at T+1.
  - If the core answers at T+1+L (L≥1), `rsp_valid` is high at T+2+L.
  - The earliest next acceptance is T+3+L, so the issue-to-issue period is L+3 cycles.
- Simultaneous `req_valid` bits are resolved in a single cycle by the round-robin rule; there is no extra arbitration cycle.

## Configuration
- Macro: `CS_IP_SCHEDULER_TIMEOUT_EN`.
- Defined:
  - A 10-bit WAIT counter is cleared on entry to WAIT and increments every WAIT cycle.
  - When the counter equals TIMEOUT-1 and `ip_out_valid=0`, the FSM moves to RESP with `rsp_result=0` and `rsp_err=1`.
  - If `ip_out_valid` arrives in the same cycle as the timeout, `ip_out_valid` wins and `rsp_err=0`.
  - A late `ip_out_valid` arriving after the timeout lands in IDLE, ISSUE or RESP and is ignored.
- Undefined: no counter is built, `rsp_err` is tied to 0, and WAIT lasts until `ip_out_valid` arrives.

## Test plan
- Reset release, then `req_valid=4'b0001`, data=256'h1, core latency L=3, result 1:
  - `req_ready=0001` in the acceptance cycle.
  - `ip_in_valid` is a single pulse one cycle later.
  - `rsp_valid=0001` with `rsp_result=1` and `rsp_err=0`, 5 cycles after acceptance.
- `req_valid=4'b1111` held for 8 jobs: grant order is 0,1,2,3,0,1,2,3, and each response goes only to its owner.
- Requester 2 asserts `req_valid` while the job for requester 1 is in WAIT: `req_ready[2]` stays 0 until IDLE, then requester 2 is accepted.
- Spurious `ip_out_valid` pulses in IDLE and ISSUE: no `rsp_valid`, and the FSM state is unchanged.
- `rst` asserted in WAIT and then released, with a new job from requester 0: the aborted job gives no response, and the new job is granted first with a correct result.
- With `CS_IP_SCHEDULER_TIMEOUT_EN` and TIMEOUT=4, the core never answers:
  - `rsp_valid` is high with `rsp_err=1` and `rsp_result=0`, 6 cycles after acceptance.
  - A repeat run where `ip_out_valid` coincides with the timeout cycle gives `rsp_err=0`.
